mcu_raster_buffer: RTL



---
 rtl/mcu_raster_buffer.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mcu_raster_buffer.sv
// Reorders 8-pixel block rows from idct_2d into raster segments through two ping-pong strip banks.
// Optional build macro MRB_OVERFLOW_DET_EN: sticky overflow flag plus a saturating dropped-row counter.
module mcu_raster_buffer #(
  parameter int BLOCKS_PER_ROW = 40,
  parameter int PIX_W          = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [8*PIX_W-1:0] row_in,
  input  logic               valid_in,
  input  logic               final_in,
  output logic               ready_out,
  output logic [8*PIX_W-1:0] data_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               line_last_out,
  output logic               frame_last_out,
  output logic               overflow_out
);

  localparam int ROW_W = 8 * PIX_W;
  localparam int DEPTH = 8 * BLOCKS_PER_ROW;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(2 * DEPTH);
  localparam int BW    = (BLOCKS_PER_ROW > 1) ? $clog2(BLOCKS_PER_ROW) : 1;
  localparam int NW    = $clog2(BLOCKS_PER_ROW + 1);
  localparam logic [BW-1:0] LAST_BLK = BW'(BLOCKS_PER_ROW - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} rd_state_t;

  // Write side and bank bookkeeping
  logic          wsel_q, wsel_d;
  logic [2:0]    wrow_q, wrow_d;
  logic [BW-1:0] wblk_q, wblk_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    fin_q, fin_d;
  logic [NW-1:0] nblk_q [2];
  logic [NW-1:0] nblk_d [2];
  logic          wr_en, wclose;
  logic [AW-1:0] waddr;
  logic [RW-1:0] widx;

  // Read side
  rd_state_t     state_q, state_d;
  logic          pf_q, pf_d;
  logic          fsel_q, fsel_d;
  logic [2:0]    rline_q, rline_d;
  logic [BW-1:0] rseg_q, rseg_d;
  logic          p_ll_q, p_ll_d, p_fl_q, p_fl_d, p_bl_q, p_bl_d, p_bank_q, p_bank_d;
  logic [ROW_W-1:0] data_q, data_d;
  logic          ll_q, ll_d, fl_q, fl_d, bl_q, bl_d, obank_q, obank_d;
  logic          rd_en, out_load, slot_free, rel, last_seg;
  logic [AW-1:0] raddr;
  logic [RW-1:0] ridx;

  logic [ROW_W-1:0] mem [2*DEPTH];
  logic [ROW_W-1:0] ram_rd_q;

  assign ready_out      = ~full_q[wsel_q];
  assign data_out       = data_q;
  assign line_last_out  = ll_q;
  assign frame_last_out = fl_q;

  always_comb begin
    wr_en  = valid_in && ready_out;
    waddr  = AW'(wrow_q) * AW'(BLOCKS_PER_ROW) + AW'(wblk_q);
    widx   = wsel_q ? (RW'(DEPTH) + RW'(waddr)) : RW'(waddr);
    wclose = wr_en && (wrow_q == 3'd7) && ((wblk_q == LAST_BLK) || final_in);
    wrow_d = wrow_q;
    wblk_d = wblk_q;
    wsel_d = wsel_q;
    full_d = full_q;
    fin_d  = fin_q;
    nblk_d = nblk_q;
    // Release and close always target different banks: a closing bank was EMPTY.
    if (rel) begin
      full_d[obank_q] = 1'b0;
    end
    if (wclose) begin
      full_d[wsel_q] = 1'b1;
      fin_d[wsel_q]  = final_in;
      nblk_d[wsel_q] = NW'(wblk_q) + NW'(1);
      wrow_d         = '0;
      wblk_d         = '0;
      wsel_d         = ~wsel_q;
    end else if (wr_en) begin
      if (wrow_q == 3'd7) begin
        wrow_d = '0;
        wblk_d = wblk_q + BW'(1);
      end else begin
        wrow_d = wrow_q + 3'd1;
      end
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pf_q    <= pf_d;
    end
  end

  // Read FSM: next state; pf_q marks a prefetched segment waiting in the RAM register
  always_comb begin
    state_d = state_q;
    pf_d    = pf_q;
    case (state_q)
      S_IDLE: begin
        state_d = rd_en ? S_FETCH : S_IDLE;
        pf_d    = 1'b0;
      end
      S_FETCH: begin
        state_d = S_HOLD;
        pf_d    = rd_en;
      end
      S_HOLD: begin
        if (ready_in) begin
          if (pf_q) begin
            state_d = S_HOLD;
            pf_d    = rd_en;
          end else begin
            state_d = rd_en ? S_FETCH : S_IDLE;
            pf_d    = 1'b0;
          end
        end else begin
          pf_d = pf_q || rd_en;
        end
      end
      default: begin
        state_d = S_IDLE;
        pf_d    = 1'b0;
      end
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    slot_free = 1'b0;
    out_load  = 1'b0;
    rel       = 1'b0;
    case (state_q)
      S_IDLE:  slot_free = 1'b1;
      S_FETCH: begin
        slot_free = 1'b1;
        out_load  = 1'b1;
      end
      S_HOLD: begin
        slot_free = !pf_q || ready_in;
        out_load  = pf_q && ready_in;
        rel       = ready_in && bl_q;
      end
      default: slot_free = 1'b0;
    endcase
    rd_en     = full_q[fsel_q] && slot_free;
    valid_out = (state_q == S_HOLD);
  end

  always_comb begin
    last_seg = (NW'(rseg_q) + NW'(1)) == nblk_q[fsel_q];
    raddr    = AW'(rline_q) * AW'(BLOCKS_PER_ROW) + AW'(rseg_q);
    ridx     = fsel_q ? (RW'(DEPTH) + RW'(raddr)) : RW'(raddr);
    fsel_d   = fsel_q;
    rline_d  = rline_q;
    rseg_d   = rseg_q;
    p_ll_d   = p_ll_q;
    p_fl_d   = p_fl_q;
    p_bl_d   = p_bl_q;
    p_bank_d = p_bank_q;
    data_d   = data_q;
    ll_d     = ll_q;
    fl_d     = fl_q;
    bl_d     = bl_q;
    obank_d  = obank_q;
    if (rd_en) begin
      p_ll_d   = last_seg;
      p_bl_d   = last_seg && (rline_q == 3'd7);
      p_fl_d   = p_bl_d && fin_q[fsel_q];
      p_bank_d = fsel_q;
      // The fetch pointer moves on to the other bank right after issuing the last read.
      if (last_seg) begin
        rseg_d  = '0;
        rline_d = rline_q + 3'd1;
        if (rline_q == 3'd7) begin
          fsel_d = ~fsel_q;
        end
      end else begin
        rseg_d = rseg_q + BW'(1);
      end
    end
    if (out_load) begin
      data_d  = ram_rd_q;
      ll_d    = p_ll_q;
      fl_d    = p_fl_q;
      bl_d    = p_bl_q;
      obank_d = p_bank_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wsel_q    <= 1'b0;
      wrow_q    <= '0;
      wblk_q    <= '0;
      full_q    <= '0;
      fin_q     <= '0;
      nblk_q[0] <= '0;
      nblk_q[1] <= '0;
      fsel_q    <= 1'b0;
      rline_q   <= '0;
      rseg_q    <= '0;
      p_ll_q    <= 1'b0;
      p_fl_q    <= 1'b0;
      p_bl_q    <= 1'b0;
      p_bank_q  <= 1'b0;
      data_q    <= '0;
      ll_q      <= 1'b0;
      fl_q      <= 1'b0;
      bl_q      <= 1'b0;
      obank_q   <= 1'b0;
    end else begin
      wsel_q    <= wsel_d;
      wrow_q    <= wrow_d;
      wblk_q    <= wblk_d;
      full_q    <= full_d;
      fin_q     <= fin_d;
      nblk_q    <= nblk_d;
      fsel_q    <= fsel_d;
      rline_q   <= rline_d;
      rseg_q    <= rseg_d;
      p_ll_q    <= p_ll_d;
      p_fl_q    <= p_fl_d;
      p_bl_q    <= p_bl_d;
      p_bank_q  <= p_bank_d;
      data_q    <= data_d;
      ll_q      <= ll_d;
      fl_q      <= fl_d;
      bl_q      <= bl_d;
      obank_q   <= obank_d;
    end
  end

  // Strip storage: both banks share one array, bank 1 offset by DEPTH
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[widx] <= row_in;
    end
    if (rd_en) begin
      ram_rd_q <= mem[ridx];
    end
  end

`ifdef MRB_OVERFLOW_DET_EN
  logic        ovf_q, ovf_d, drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop       = valid_in && !ready_out;
    ovf_d      = ovf_q || drop;
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow_out = ovf_q;
`else
  assign overflow_out = 1'b0;
`endif

endmodule
